// File: rtl/time_set_ctrl.sv
// Time-of-day set controller: RUN / SET_HOUR / SET_MIN editing with button edges,
// load strobes to the hour/minute counters, idle-timeout abort and field blink.
module time_set_ctrl #(
  parameter int TIMEOUT_S = 30,
  parameter int HOUR_MOD  = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       carry_sec,
  input  logic       carry_min,
  input  logic [5:0] count_hour,
  input  logic [5:0] count_min,
  output logic       enable_sec,
  output logic       enable_min,
  output logic       enable_hour,
  output logic       load_hour,
  output logic       load_min,
  output logic [5:0] data_hour,
  output logic [5:0] data_min,
  output logic       clear_sec,
  output logic [1:0] mode,
  output logic       blink
);
  typedef enum logic [1:0] {RUN = 2'b00, SET_HOUR = 2'b01, SET_MIN = 2'b10} state_t;
  localparam int IW = $clog2(TIMEOUT_S + 1);

  state_t          state_q, state_d;
  logic            mode_q, inc_q, mode_arm, inc_arm;
  logic            mode_edge, inc_edge, any_edge, timeout;
  logic [IW-1:0]   idle_q;
  logic [5:0]      edit_hour, edit_min;
  logic            load_hour_q, load_min_q, blink_q;
  logic            ld_hour_d, ld_min_d;

  function automatic logic [5:0] cap(input logic [5:0] v, input int lim);
    return (int'(v) >= lim) ? 6'd0 : v;
  endfunction

  // arm flags keep a button held across reset release from looking like a press
  assign mode_edge = btn_mode & ~mode_q & mode_arm;
  assign inc_edge  = btn_inc & ~inc_q & inc_arm;
  assign any_edge  = mode_edge | inc_edge;
  assign timeout   = (state_q != RUN) && tick_1hz && !any_edge &&
                     (idle_q == IW'(TIMEOUT_S - 1));

  always_comb begin
    state_d   = state_q;
    ld_hour_d = 1'b0;
    ld_min_d  = 1'b0;
    case (state_q)
      RUN:      if (mode_edge) state_d = SET_HOUR;
      SET_HOUR: if (mode_edge) begin
                  state_d   = SET_MIN;
                  ld_hour_d = 1'b1;
                end else if (timeout) state_d = RUN;
      SET_MIN:  if (mode_edge) begin
                  state_d  = RUN;
                  ld_min_d = 1'b1;
                end else if (timeout) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q      <= 1'b0;
      inc_q       <= 1'b0;
      mode_arm    <= ~btn_mode;
      inc_arm     <= ~btn_inc;
      edit_hour   <= '0;
      edit_min    <= '0;
      idle_q      <= '0;
      blink_q     <= 1'b0;
      load_hour_q <= 1'b0;
      load_min_q  <= 1'b0;
    end else begin
      mode_q      <= btn_mode;
      inc_q       <= btn_inc;
      if (!btn_mode) mode_arm <= 1'b1;
      if (!btn_inc)  inc_arm  <= 1'b1;
      load_hour_q <= ld_hour_d;
      load_min_q  <= ld_min_d;

      // mode wins over inc in the same cycle
      if (state_q == RUN && mode_edge)
        edit_hour <= cap(count_hour, HOUR_MOD);
      else if (state_q == SET_HOUR && inc_edge && !mode_edge)
        edit_hour <= (int'(edit_hour) >= HOUR_MOD - 1) ? 6'd0 : edit_hour + 6'd1;

      if (state_q == SET_HOUR && mode_edge)
        edit_min <= cap(count_min, 60);
      else if (state_q == SET_MIN && inc_edge && !mode_edge)
        edit_min <= (edit_min >= 6'd59) ? 6'd0 : edit_min + 6'd1;

      if (state_d == RUN || any_edge) idle_q <= '0;
      else if (tick_1hz)              idle_q <= idle_q + IW'(1);

      if (state_d == RUN)  blink_q <= 1'b0;
      else if (mode_edge)  blink_q <= 1'b1;
      else if (tick_1hz)   blink_q <= ~blink_q;
    end
  end

  logic run_en;
  assign run_en      = (state_q == RUN) && !reset;
  assign enable_sec  = run_en & tick_1hz;
  assign enable_min  = run_en & tick_1hz & carry_sec;
  assign enable_hour = run_en & tick_1hz & carry_sec & carry_min;
  assign load_hour   = load_hour_q & ~reset;
  assign load_min    = load_min_q & ~reset;
  assign clear_sec   = load_min_q & ~reset;
  assign data_hour   = edit_hour;
  assign data_min    = edit_min;
  assign mode        = state_q;
  assign blink       = blink_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed scenarios followed by random stimulus, all checked each cycle against
// a behavioural model of the set controller.
module tb_time_set_ctrl;
  localparam int TO = 30, HM = 24;

  logic       clock = 1'b0;
  logic       reset, tick_1hz, btn_mode, btn_inc, carry_sec, carry_min;
  logic [5:0] count_hour, count_min;
  logic       enable_sec, enable_min, enable_hour, load_hour, load_min, clear_sec, blink;
  logic [5:0] data_hour, data_min;
  logic [1:0] mode;

  int n_chk = 0, n_fail = 0;
  // model: 0 RUN, 1 SET_HOUR, 2 SET_MIN
  int m_mode, m_eh, m_em, m_idle, m_blink, m_ldh, m_ldm, m_pm, m_pi;

  always #5 clock = ~clock;

  time_set_ctrl #(.TIMEOUT_S(TO), .HOUR_MOD(HM)) dut (
    .clock(clock), .reset(reset), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
    .btn_inc(btn_inc), .carry_sec(carry_sec), .carry_min(carry_min),
    .count_hour(count_hour), .count_min(count_min), .enable_sec(enable_sec),
    .enable_min(enable_min), .enable_hour(enable_hour), .load_hour(load_hour),
    .load_min(load_min), .data_hour(data_hour), .data_min(data_min),
    .clear_sec(clear_sec), .mode(mode), .blink(blink));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int run;
    run = (m_mode == 0 && !reset) ? 1 : 0;
    chk("enable_sec", 32'(enable_sec), 32'(run & int'(tick_1hz)));
    chk("enable_min", 32'(enable_min), 32'(run & int'(tick_1hz & carry_sec)));
    chk("enable_hour", 32'(enable_hour), 32'(run & int'(tick_1hz & carry_sec & carry_min)));
    chk("load_hour", 32'(load_hour), 32'((m_ldh != 0 && !reset) ? 1 : 0));
    chk("load_min", 32'(load_min), 32'((m_ldm != 0 && !reset) ? 1 : 0));
    chk("clear_sec", 32'(clear_sec), 32'((m_ldm != 0 && !reset) ? 1 : 0));
    chk("mode", 32'(mode), 32'(m_mode));
    chk("blink", 32'(blink), 32'(m_blink));
    chk("data_hour", 32'(data_hour), 32'(m_eh));
    chk("data_min", 32'(data_min), 32'(m_em));
  endtask

  // Applies the rules to the inputs present at the clock edge.
  task automatic model_edge();
    bit me, ie;
    if (reset) begin
      m_mode = 0; m_eh = 0; m_em = 0; m_idle = 0; m_blink = 0; m_ldh = 0; m_ldm = 0;
      m_pm = int'(btn_mode); m_pi = int'(btn_inc);
      return;
    end
    me = btn_mode && m_pm == 0;
    ie = btn_inc && m_pi == 0;
    m_pm = int'(btn_mode); m_pi = int'(btn_inc);
    m_ldh = 0; m_ldm = 0;
    if (me) begin
      m_idle = 0;
      if (m_mode == 0) begin
        m_eh = (int'(count_hour) < HM) ? int'(count_hour) : 0; m_mode = 1; m_blink = 1;
      end else if (m_mode == 1) begin
        m_ldh = 1; m_em = (int'(count_min) < 60) ? int'(count_min) : 0; m_mode = 2; m_blink = 1;
      end else begin
        m_ldm = 1; m_mode = 0; m_blink = 0;
      end
    end else if (m_mode != 0) begin
      if (ie) begin
        m_idle = 0;
        if (m_mode == 1) m_eh = (m_eh + 1) % HM;
        else             m_em = (m_em + 1) % 60;
        if (tick_1hz) m_blink = 1 - m_blink;
      end else if (tick_1hz) begin
        m_idle++;
        m_blink = 1 - m_blink;
        if (m_idle >= TO) begin m_mode = 0; m_idle = 0; m_blink = 0; end
      end
    end
  endtask

  // Called at posedge+1 with inputs set; checks before the edge, steps the model at it.
  task automatic cycle();
    #2 check_model();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; cycle(); btn_mode = 1'b0; cycle();
  endtask

  task automatic press_inc();
    btn_inc = 1'b1; cycle(); btn_inc = 1'b0; cycle();
  endtask

  initial begin
    int act;
    reset = 1'b1; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    carry_sec = 1'b0; carry_min = 1'b0; count_hour = '0; count_min = '0;
    @(posedge clock); model_edge(); #1;

    // reset state, enables suppressed during reset even with a tick
    tick_1hz = 1'b1; carry_sec = 1'b1; carry_min = 1'b1; #1;
    chk("rst_enable_sec", 32'(enable_sec), 0);
    chk("rst_mode", 32'(mode), 0);
    cycle();
    reset = 1'b0; tick_1hz = 1'b0; cycle();

    // full cascade of enables at 23:59:59
    count_hour = 6'd23; tick_1hz = 1'b1; carry_sec = 1'b1; carry_min = 1'b1; #1;
    chk("cascade_sec", 32'(enable_sec), 1);
    chk("cascade_min", 32'(enable_min), 1);
    chk("cascade_hour", 32'(enable_hour), 1);
    cycle();
    tick_1hz = 1'b0; carry_sec = 1'b0; carry_min = 1'b0; cycle();

    // hour edit with wrap 22->23->0->1
    count_hour = 6'd22; count_min = 6'd45;
    press_mode();
    chk("sethour_mode", 32'(mode), 1);
    chk("sethour_blink", 32'(blink), 1);
    chk("sethour_data", 32'(data_hour), 22);
    repeat (3) press_inc();
    chk("hour_wrap", 32'(data_hour), 1);
    btn_mode = 1'b1; cycle();
    chk("load_hour_pulse", 32'(load_hour), 1);
    chk("load_hour_data", 32'(data_hour), 1);
    chk("setmin_mode", 32'(mode), 2);
    btn_mode = 1'b0; cycle();
    chk("load_hour_single", 32'(load_hour), 0);
    chk("min_capture", 32'(data_min), 45);

    // minute wrap 59->0 then commit
    repeat (14) press_inc();
    chk("min_59", 32'(data_min), 59);
    press_inc();
    chk("min_wrap", 32'(data_min), 0);
    btn_mode = 1'b1; cycle();
    chk("load_min_pulse", 32'(load_min), 1);
    chk("clear_sec_pulse", 32'(clear_sec), 1);
    chk("commit_mode", 32'(mode), 0);
    btn_mode = 1'b0; cycle();
    chk("load_min_single", 32'(load_min), 0);

    // idle timeout abort
    press_mode();
    repeat (TO - 1) begin tick_1hz = 1'b1; cycle(); tick_1hz = 1'b0; cycle(); end
    chk("timeout_not_yet", 32'(mode), 1);
    tick_1hz = 1'b1; cycle(); tick_1hz = 1'b0;
    chk("timeout_mode", 32'(mode), 0);
    chk("timeout_no_load", 32'(load_hour), 0);
    tick_1hz = 1'b1; #1;
    chk("timeout_enables", 32'(enable_sec), 1);
    cycle(); tick_1hz = 1'b0;

    // simultaneous mode and inc: mode wins
    press_mode();
    btn_mode = 1'b1; btn_inc = 1'b1; cycle();
    chk("simul_mode", 32'(mode), 2);
    chk("simul_hour", 32'(data_hour), 22);
    btn_mode = 1'b0; btn_inc = 1'b0; cycle();

    // reset mid-edit aborts
    reset = 1'b1; cycle();
    chk("rst_edit_mode", 32'(mode), 0);
    chk("rst_edit_blink", 32'(blink), 0);
    chk("rst_edit_load", 32'(load_min), 0);
    chk("rst_edit_clear", 32'(clear_sec), 0);
    reset = 1'b0; cycle();

    // button held through reset release gives no edge
    btn_mode = 1'b1; reset = 1'b1; cycle(); reset = 1'b0; cycle(); cycle();
    chk("held_no_edge", 32'(mode), 0);
    btn_mode = 1'b0; cycle(); btn_mode = 1'b1; cycle();
    chk("repress_edge", 32'(mode), 1);
    btn_mode = 1'b0; cycle();

    // out-of-range captures replaced by 0
    press_mode(); press_mode();
    count_hour = 6'd40; press_mode();
    chk("oor_hour", 32'(data_hour), 0);
    count_min = 6'd62; press_mode();
    chk("oor_min", 32'(data_min), 0);
    press_mode();

    // random phase with alternating busy / quiet button activity
    act = 8;
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) act = ($urandom % 3 == 0) ? 400 : 8;
      tick_1hz   = ($urandom % 3 == 0);
      carry_sec  = $urandom % 2;
      carry_min  = $urandom % 2;
      count_hour = 6'($urandom % 64);
      count_min  = 6'($urandom % 64);
      if ($urandom % act == 0) btn_mode = ~btn_mode;
      if ($urandom % act == 0) btn_inc = ~btn_inc;
      reset = ($urandom % 300 == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
